// File: rtl/gcm_aes_axi4_burst_slave.sv
// AXI4 burst slave with a word-addressed staging buffer for the GCM-AES core.
// Independent write/read FSMs, FIXED/INCR/WRAP bursts, byte strobes and SLVERR.
module gcm_aes_axi4_burst_slave #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 12,
  parameter int unsigned C_S_AXI_ID_WIDTH   = 1,
  parameter int unsigned C_MEM_DEPTH        = 256
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  // Write address channel
  input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [7:0]                      S_AXI_AWLEN,
  input  logic [2:0]                      S_AXI_AWSIZE,
  input  logic [1:0]                      S_AXI_AWBURST,
  input  logic                            S_AXI_AWLOCK,
  input  logic [3:0]                      S_AXI_AWCACHE,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic [3:0]                      S_AXI_AWQOS,
  input  logic [3:0]                      S_AXI_AWREGION,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  // Write data channel
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WLAST,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  // Write response channel
  output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_BID,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  // Read address channel
  input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [7:0]                      S_AXI_ARLEN,
  input  logic [2:0]                      S_AXI_ARSIZE,
  input  logic [1:0]                      S_AXI_ARBURST,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  // Read data channel
  output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_RID,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RLAST,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY
);

  localparam int unsigned DW      = C_S_AXI_DATA_WIDTH;
  localparam int unsigned AW      = C_S_AXI_ADDR_WIDTH;
  localparam int unsigned IW      = C_S_AXI_ID_WIDTH;
  localparam int unsigned Bytes   = DW / 8;
  localparam int unsigned AddrLsb = $clog2(Bytes);
  localparam int unsigned MemIdxW = $clog2(C_MEM_DEPTH);

  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstIncr  = 2'b01;
  localparam logic [1:0] BurstWrap  = 2'b10;

  typedef enum logic [1:0] {WIdle, WData, WResp} wstate_e;
  typedef enum logic {RIdle, RData} rstate_e;

  function automatic logic size_bad(input logic [2:0] s);
    return 32'(s) > AddrLsb;
  endfunction

  function automatic logic wrap_bad(input logic [1:0] b, input logic [7:0] l);
    return (b == BurstWrap) && !(l == 8'd1 || l == 8'd3 || l == 8'd7 || l == 8'd15);
  endfunction

  function automatic logic fmt_err(input logic [2:0] s, input logic [1:0] b, input logic [7:0] l);
    return size_bad(s) | wrap_bad(b, l);
  endfunction

  function automatic logic in_range(input logic [AW-1:0] a);
    return (a >> AddrLsb) < AW'(C_MEM_DEPTH);
  endfunction

  function automatic logic [MemIdxW-1:0] mem_idx(input logic [AW-1:0] a);
    return MemIdxW'(a >> AddrLsb);
  endfunction

  // Oversized beats advance as full width; illegal WRAP lengths advance as INCR.
  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a, input logic [2:0] s,
                                              input logic [7:0] l, input logic [1:0] b);
    logic [2:0]    es;
    logic [1:0]    eb;
    logic [AW-1:0] incr;
    logic [AW-1:0] mask;
    logic [AW-1:0] res;
    es   = size_bad(s) ? 3'(AddrLsb) : s;
    eb   = wrap_bad(b, l) ? BurstIncr : b;
    incr = AW'(1) << es;
    mask = AW'(((32'(l) + 32'd1) << es) - 32'd1);
    case (eb)
      BurstFixed: res = a;
      BurstWrap:  res = (a & ~mask) | ((a + incr) & mask);
      default:    res = a + incr;
    endcase
    return res;
  endfunction

  logic [DW-1:0] mem [C_MEM_DEPTH];

  // Holds the address ready-signals low until the first edge after reset release.
  logic rdy_q;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) rdy_q <= 1'b0;
    else          rdy_q <= 1'b1;
  end

  // ---------------------------------------------------------------- write path
  wstate_e       wstate_q, wstate_d;
  logic [IW-1:0] awid_q, awid_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [7:0]    wlen_q, wlen_d;
  logic [2:0]    wsize_q, wsize_d;
  logic [1:0]    wburst_q, wburst_d;
  logic [7:0]    wcnt_q, wcnt_d;
  logic          werr_q, werr_d;
  logic          mem_we;
  logic          w_in_range;
  logic          w_last_exp;

  assign w_in_range = in_range(waddr_q);
  assign w_last_exp = (wcnt_q == wlen_q);

  always_comb begin
    wstate_d = wstate_q;
    awid_d   = awid_q;
    waddr_d  = waddr_q;
    wlen_d   = wlen_q;
    wsize_d  = wsize_q;
    wburst_d = wburst_q;
    wcnt_d   = wcnt_q;
    werr_d   = werr_q;
    mem_we   = 1'b0;
    case (wstate_q)
      WIdle: begin
        if (S_AXI_AWVALID && rdy_q) begin
          awid_d   = S_AXI_AWID;
          waddr_d  = S_AXI_AWADDR;
          wlen_d   = S_AXI_AWLEN;
          wsize_d  = S_AXI_AWSIZE;
          wburst_d = S_AXI_AWBURST;
          wcnt_d   = 8'd0;
          werr_d   = 1'b0;
          wstate_d = WData;
        end
      end
      WData: begin
        if (S_AXI_WVALID) begin
          mem_we  = w_in_range;
          werr_d  = werr_q | fmt_err(wsize_q, wburst_q, wlen_q) | !w_in_range
                    | (S_AXI_WLAST != w_last_exp);
          waddr_d = next_addr(waddr_q, wsize_q, wlen_q, wburst_q);
          wcnt_d  = wcnt_q + 8'd1;
          if (w_last_exp) wstate_d = WResp;
        end
      end
      WResp: begin
        if (S_AXI_BREADY) wstate_d = WIdle;
      end
      default: wstate_d = WIdle;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wstate_q <= WIdle;
      awid_q   <= '0;
      waddr_q  <= '0;
      wlen_q   <= '0;
      wsize_q  <= '0;
      wburst_q <= '0;
      wcnt_q   <= '0;
      werr_q   <= 1'b0;
    end else begin
      wstate_q <= wstate_d;
      awid_q   <= awid_d;
      waddr_q  <= waddr_d;
      wlen_q   <= wlen_d;
      wsize_q  <= wsize_d;
      wburst_q <= wburst_d;
      wcnt_q   <= wcnt_d;
      werr_q   <= werr_d;
    end
  end

  // Buffer is deliberately not reset so staged data survives ARESETN.
  always_ff @(posedge ACLK) begin
    if (mem_we) begin
      for (int i = 0; i < int'(Bytes); i++) begin
        if (S_AXI_WSTRB[i]) mem[mem_idx(waddr_q)][8*i +: 8] <= S_AXI_WDATA[8*i +: 8];
      end
    end
  end

  assign S_AXI_AWREADY = (wstate_q == WIdle) && rdy_q;
  assign S_AXI_WREADY  = (wstate_q == WData);
  assign S_AXI_BVALID  = (wstate_q == WResp);
  assign S_AXI_BID     = awid_q;
  assign S_AXI_BRESP   = {werr_q, 1'b0};

  // ----------------------------------------------------------------- read path
  rstate_e       rstate_q, rstate_d;
  logic [IW-1:0] rid_q, rid_d;
  logic [AW-1:0] raddr_q, raddr_d;
  logic [7:0]    rlen_q, rlen_d;
  logic [2:0]    rsize_q, rsize_d;
  logic [1:0]    rburst_q, rburst_d;
  logic [7:0]    rcnt_q, rcnt_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [1:0]    rresp_q, rresp_d;
  logic          rlast_q, rlast_d;

  // Beat to load: from AR on the handshake, else the next address of the burst.
  logic [AW-1:0] ld_addr;
  logic [2:0]    ld_size;
  logic [7:0]    ld_len;
  logic [1:0]    ld_burst;
  logic          ld_in_range;
  logic [DW-1:0] ld_data;
  logic [1:0]    ld_resp;

  always_comb begin
    if (rstate_q == RIdle) begin
      ld_addr  = S_AXI_ARADDR;
      ld_size  = S_AXI_ARSIZE;
      ld_len   = S_AXI_ARLEN;
      ld_burst = S_AXI_ARBURST;
    end else begin
      ld_addr  = raddr_q;
      ld_size  = rsize_q;
      ld_len   = rlen_q;
      ld_burst = rburst_q;
    end
    ld_in_range = in_range(ld_addr);
    ld_data     = ld_in_range ? mem[mem_idx(ld_addr)] : '0;
    ld_resp     = {fmt_err(ld_size, ld_burst, ld_len) | !ld_in_range, 1'b0};
  end

  always_comb begin
    rstate_d = rstate_q;
    rid_d    = rid_q;
    raddr_d  = raddr_q;
    rlen_d   = rlen_q;
    rsize_d  = rsize_q;
    rburst_d = rburst_q;
    rcnt_d   = rcnt_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    rlast_d  = rlast_q;
    case (rstate_q)
      RIdle: begin
        if (S_AXI_ARVALID && rdy_q) begin
          rid_d    = S_AXI_ARID;
          rlen_d   = S_AXI_ARLEN;
          rsize_d  = S_AXI_ARSIZE;
          rburst_d = S_AXI_ARBURST;
          raddr_d  = next_addr(S_AXI_ARADDR, S_AXI_ARSIZE, S_AXI_ARLEN, S_AXI_ARBURST);
          rcnt_d   = 8'd0;
          rdata_d  = ld_data;
          rresp_d  = ld_resp;
          rlast_d  = (S_AXI_ARLEN == 8'd0);
          rstate_d = RData;
        end
      end
      RData: begin
        if (S_AXI_RREADY) begin
          if (rlast_q) begin
            rlast_d  = 1'b0;
            rstate_d = RIdle;
          end else begin
            rcnt_d  = rcnt_q + 8'd1;
            raddr_d = next_addr(raddr_q, rsize_q, rlen_q, rburst_q);
            rdata_d = ld_data;
            rresp_d = ld_resp;
            rlast_d = ((rcnt_q + 8'd1) == rlen_q);
          end
        end
      end
      default: rstate_d = RIdle;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rstate_q <= RIdle;
      rid_q    <= '0;
      raddr_q  <= '0;
      rlen_q   <= '0;
      rsize_q  <= '0;
      rburst_q <= '0;
      rcnt_q   <= '0;
      rdata_q  <= '0;
      rresp_q  <= '0;
      rlast_q  <= 1'b0;
    end else begin
      rstate_q <= rstate_d;
      rid_q    <= rid_d;
      raddr_q  <= raddr_d;
      rlen_q   <= rlen_d;
      rsize_q  <= rsize_d;
      rburst_q <= rburst_d;
      rcnt_q   <= rcnt_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
      rlast_q  <= rlast_d;
    end
  end

  assign S_AXI_ARREADY = (rstate_q == RIdle) && rdy_q;
  assign S_AXI_RVALID  = (rstate_q == RData);
  assign S_AXI_RID     = rid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RLAST   = rlast_q;

  logic unused_aw_side;
  assign unused_aw_side = ^{S_AXI_AWLOCK, S_AXI_AWCACHE, S_AXI_AWPROT, S_AXI_AWQOS,
                            S_AXI_AWREGION};

endmodule
